// File: rtl/hdmux_pkg.sv
// hdmux_pkg: shared types and helpers for the round-robin registered mux.
//   hdmux_state_e  - packet-lock state (IDLE / LOCKED). Only used when the
//                    HDMUX_LOCK_EN macro is defined.
//   hdmux_next_ptr - rotating-pointer increment with wrap from n-1 back to 0.
package hdmux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } hdmux_state_e;

  function automatic int hdmux_next_ptr(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/hdmux_rr_pick.sv
// hdmux_rr_pick: combinational rotating-priority encoder.
//   req     [N]    - request vector
//   ptr     [SELW] - highest-priority index for this search
//   gnt_oh  [N]    - one-hot grant (zero when no request)
//   gnt_idx [SELW] - binary index of the grant (0 when no request)
//   any            - at least one request present
// The search visits ptr, ptr+1, ... wrapping N-1 -> 0, and the first set
// request wins.
module hdmux_rr_pick
  import hdmux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt_oh,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int idx;
    logic [SELW-1:0] idx_s;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so a single subtraction is enough to wrap.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_s = SELW'(idx);
      if (!any && req[idx_s]) begin
        any            = 1'b1;
        gnt_idx        = idx_s;
        gnt_oh[idx_s]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdmux_rr_arb.sv
// hdmux_rr_arb: N-input, W-bit registered multiplexer with round-robin
// arbitration and valid/ready handshakes on every port.
//   CK, RST         - clock (rising edge), asynchronous active-high reset
//   A_VALID/A_READY - per-channel handshake; A_READY is one-hot or zero
//   A_DATA          - channel i in bits [i*W +: W]
//   A_LAST          - end-of-packet marker (packet lock only)
//   Z_VALID/Z_READY - output handshake; the output register holds one beat
//   Z_DATA, Z_SEL   - registered beat and the index of its source channel
// Optional feature: define HDMUX_LOCK_EN to hold the grant on one channel
// from the first beat of a packet until the beat carrying A_LAST.
// A_READY depends combinationally on Z_READY (and never on A_DATA).
module hdmux_rr_arb
  import hdmux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [N-1:0]      A_VALID,
  input  logic [N*W-1:0]    A_DATA,
  input  logic [N-1:0]      A_LAST,
  output logic [N-1:0]      A_READY,
  output logic              Z_VALID,
  output logic [W-1:0]      Z_DATA,
  output logic [SELW-1:0]   Z_SEL,
  input  logic              Z_READY
);

  logic            z_valid_q, z_valid_d;
  logic [W-1:0]    z_data_q, z_data_d;
  logic [SELW-1:0] z_sel_q, z_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [N-1:0]    pick_oh;
  logic [SELW-1:0] pick_idx;
  logic            pick_any;

  logic [N-1:0]    gnt_oh;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_any;
  logic            open;
  logic            accept;

  logic [W-1:0]    chan_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = A_DATA[gi*W +: W];
    end
  endgenerate

  hdmux_rr_pick #(.N(N)) u_pick (
    .req     (A_VALID),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

`ifdef HDMUX_LOCK_EN
  hdmux_state_e    state_q, state_d;
  logic [SELW-1:0] lock_q, lock_d;
  logic            locked;

  assign locked = (state_q == LOCKED);

  // While locked, only the lock channel may be granted, even if it is idle.
  assign gnt_idx = locked ? lock_q : pick_idx;
  assign gnt_oh  = locked ? ({{(N-1){1'b0}}, 1'b1} << lock_q) : pick_oh;
  assign gnt_any = locked ? A_VALID[lock_q] : pick_any;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (accept) begin
      if (!locked && !A_LAST[gnt_idx]) begin
        state_d = LOCKED;
        lock_d  = gnt_idx;
      end else if (locked && A_LAST[gnt_idx]) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^A_LAST;

  assign gnt_idx = pick_idx;
  assign gnt_oh  = pick_oh;
  assign gnt_any = pick_any;
`endif

  // The output register can take a beat when empty or draining this cycle.
  assign open    = ~z_valid_q | Z_READY;
  assign accept  = gnt_any & open;
  assign A_READY = (accept && !RST) ? gnt_oh : '0;

  always_comb begin
    z_valid_d = z_valid_q;
    z_data_d  = z_data_q;
    z_sel_d   = z_sel_q;
    ptr_d     = ptr_q;
    if (accept) begin
      z_valid_d = 1'b1;
      z_data_d  = chan_data[gnt_idx];
      z_sel_d   = gnt_idx;
`ifdef HDMUX_LOCK_EN
      // The pointer only moves on a fresh arbitration decision, so after a
      // packet it already points just past the lock channel.
      if (!locked) ptr_d = SELW'(hdmux_next_ptr(int'(gnt_idx), N));
`else
      ptr_d = SELW'(hdmux_next_ptr(int'(gnt_idx), N));
`endif
    end else if (z_valid_q && Z_READY) begin
      z_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      z_valid_q <= 1'b0;
      z_data_q  <= '0;
      z_sel_q   <= '0;
      ptr_q     <= '0;
    end else begin
      z_valid_q <= z_valid_d;
      z_data_q  <= z_data_d;
      z_sel_q   <= z_sel_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Z_VALID = z_valid_q;
  assign Z_DATA  = z_data_q;
  assign Z_SEL   = z_sel_q;

endmodule

// File: tb/tb_hdmux_rr_arb.sv
// tb_hdmux_rr_arb: self-checking bench for hdmux_rr_arb (N=4, W=8).
// A behavioural model tracks the rotating pointer, the output beat and the
// optional packet lock; every cycle the DUT's A_READY and Z_* are compared
// against it and, for the directed scenarios, against fixed expected values.
module tb_hdmux_rr_arb;

  localparam int N = 4;
  localparam int W = 8;
  localparam int SELW = 2;

  logic            CK = 1'b0;
  logic            RST;
  logic [N-1:0]    A_VALID;
  logic [N*W-1:0]  A_DATA;
  logic [N-1:0]    A_LAST;
  logic [N-1:0]    A_READY;
  logic            Z_VALID;
  logic [W-1:0]    Z_DATA;
  logic [SELW-1:0] Z_SEL;
  logic            Z_READY;

  int checks = 0;
  int errors = 0;

  hdmux_rr_arb #(.N(N), .W(W)) dut (
    .CK      (CK),
    .RST     (RST),
    .A_VALID (A_VALID),
    .A_DATA  (A_DATA),
    .A_LAST  (A_LAST),
    .A_READY (A_READY),
    .Z_VALID (Z_VALID),
    .Z_DATA  (Z_DATA),
    .Z_SEL   (Z_SEL),
    .Z_READY (Z_READY)
  );

  always #5 CK = ~CK;

  // ---------------- behavioural reference model ----------------
  int              m_ptr;
  bit              m_zv;
  logic [W-1:0]    m_zd;
  logic [SELW-1:0] m_zs;
  bit              m_locked;
  int              m_lock;

  function automatic int m_grant();
    if (m_locked) return A_VALID[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (A_VALID[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = m_grant();
    if (RST) return '0;
    if (g >= 0 && (!m_zv || Z_READY)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_zv = 0; m_zd = '0; m_zs = '0; m_locked = 0; m_lock = 0;
  endtask

  // Evaluate the transfer with the inputs currently applied, take one
  // clock edge, update the model, and return 2 time units after the edge.
  task automatic step();
    int g;
    bit acc;
    g = m_grant();
    acc = (g >= 0) && (!m_zv || Z_READY);
    @(posedge CK);
    if (acc) begin
      m_zv = 1;
      m_zd = A_DATA[g*W +: W];
      m_zs = SELW'(g);
`ifdef HDMUX_LOCK_EN
      if (!m_locked) begin
        m_ptr = (g + 1) % N;
        if (!A_LAST[g]) begin m_locked = 1; m_lock = g; end
      end else if (A_LAST[g]) begin
        m_locked = 0;
      end
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (m_zv && Z_READY) begin
      m_zv = 0;
    end
    #2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; A_VALID = '1; A_DATA = '0; A_LAST = '1; Z_READY = 1'b1;
    m_reset();
    repeat (2) @(posedge CK);
    #2;
    checks++;
    if (A_READY !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_in_reset: got %b expected 0000", A_READY);
    end
    A_VALID = '0;
    RST = 1'b0;
    #1;
    checks++;
    if (Z_VALID !== 1'b0) begin errors++; $display("FAIL reset_zvalid: got %b expected 0", Z_VALID); end
    checks++;
    if (Z_DATA !== 8'h00) begin errors++; $display("FAIL reset_zdata: got %h expected 00", Z_DATA); end
    checks++;
    if (Z_SEL !== 2'd0) begin errors++; $display("FAIL reset_zsel: got %0d expected 0", Z_SEL); end
    checks++;
    if (A_READY !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", A_READY); end
    $display("reset: Z_VALID=%b Z_DATA=%h Z_SEL=%0d A_READY=%b", Z_VALID, Z_DATA, Z_SEL, A_READY);
  endtask

  task automatic test_round_robin();
    int exp_sel [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_dat [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    A_DATA = {8'h43, 8'h32, 8'h21, 8'h10};
    A_VALID = 4'b1111; A_LAST = '1; Z_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] er;
      er = '0; er[exp_sel[i]] = 1'b1;
      #1;
      checks++;
      if (A_READY !== er || A_READY !== m_ready()) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, A_READY, er);
      end
      step();
      checks++;
      if (Z_VALID !== 1'b1 || Z_SEL !== SELW'(exp_sel[i]) || Z_DATA !== exp_dat[i]) begin
        errors++;
        $display("FAIL rr_beat[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                 i, Z_VALID, Z_SEL, Z_DATA, exp_sel[i], exp_dat[i]);
      end
      $display("round_robin beat %0d: Z_SEL=%0d Z_DATA=%h", i, Z_SEL, Z_DATA);
    end
  endtask

  task automatic test_wrap();
    int exp_sel [4] = '{3, 0, 3, 0};
    // Grant channel 2 alone so the pointer lands on 3.
    A_VALID = 4'b0100; Z_READY = 1'b1;
    #1;
    step();
    checks++;
    if (Z_SEL !== 2'd2) begin errors++; $display("FAIL wrap_setup: got sel=%0d expected 2", Z_SEL); end
    A_VALID = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (A_READY !== m_ready()) begin
        errors++; $display("FAIL wrap_ready[%0d]: got %b expected %b", i, A_READY, m_ready());
      end
      step();
      checks++;
      if (Z_SEL !== SELW'(exp_sel[i]) || Z_SEL !== m_zs || Z_DATA !== m_zd) begin
        errors++;
        $display("FAIL wrap_beat[%0d]: got sel=%0d data=%h expected sel=%0d data=%h",
                 i, Z_SEL, Z_DATA, exp_sel[i], m_zd);
      end
      $display("wrap beat %0d: Z_SEL=%0d Z_DATA=%h", i, Z_SEL, Z_DATA);
    end
  endtask

  task automatic test_back_pressure();
    // Load a beat from channel 2 (pointer was 1 after the wrap test).
    A_DATA = {8'h43, 8'h32, 8'h21, 8'h10};
    A_VALID = 4'b0100; Z_READY = 1'b1;
    #1;
    step();
    checks++;
    if (Z_SEL !== 2'd2 || Z_DATA !== 8'h32 || Z_VALID !== 1'b1) begin
      errors++; $display("FAIL bp_load: got v=%b sel=%0d data=%h expected v=1 sel=2 data=32",
                         Z_VALID, Z_SEL, Z_DATA);
    end
    // Stall for 3 cycles with channels 0 and 2 requesting and new data.
    Z_READY = 1'b0; A_VALID = 4'b0101;
    A_DATA = {8'h43, 8'h5A, 8'h21, 8'h77};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (A_READY !== 4'b0000) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, A_READY);
      end
      step();
      checks++;
      if (Z_VALID !== 1'b1 || Z_DATA !== 8'h32 || Z_SEL !== 2'd2) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=2 data=32",
                           i, Z_VALID, Z_SEL, Z_DATA);
      end
      $display("back_pressure stall %0d: Z_DATA=%h A_READY=%b", i, Z_DATA, A_READY);
    end
    // Release: pointer still 3, so channel 0 is next and is accepted at once.
    Z_READY = 1'b1;
    #1;
    checks++;
    if (A_READY !== 4'b0001) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 0001", A_READY);
    end
    step();
    checks++;
    if (Z_VALID !== 1'b1 || Z_SEL !== 2'd0 || Z_DATA !== 8'h77) begin
      errors++; $display("FAIL bp_release_beat: got v=%b sel=%0d data=%h expected v=1 sel=0 data=77",
                         Z_VALID, Z_SEL, Z_DATA);
    end
    $display("back_pressure release: Z_SEL=%0d Z_DATA=%h", Z_SEL, Z_DATA);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      A_VALID = N'($urandom);
      A_DATA  = {$urandom};
      A_LAST  = N'($urandom);
      Z_READY = ($urandom % 4) != 0;
      #1;
      checks++;
      if (A_READY !== m_ready()) begin
        errors++; bad++;
        $display("FAIL random_ready[%0d]: got %b expected %b", i, A_READY, m_ready());
      end
      step();
      checks++;
      if (Z_VALID !== m_zv || Z_DATA !== m_zd || Z_SEL !== m_zs) begin
        errors++; bad++;
        $display("FAIL random_out[%0d]: got v=%b sel=%0d data=%h expected v=%b sel=%0d data=%h",
                 i, Z_VALID, Z_SEL, Z_DATA, m_zv, m_zs, m_zd);
      end
    end
    $display("random: 400 cycles, %0d disagreements", bad);
  endtask

  task automatic test_fairness();
    A_VALID = '1; A_LAST = '1; Z_READY = 1'b1;
    A_DATA = {8'h43, 8'h32, 8'h21, 8'h10};
    repeat (2) begin #1; step(); end
    for (int w = 0; w < 3; w++) begin
      int cnt [N];
      for (int c = 0; c < N; c++) cnt[c] = 0;
      for (int i = 0; i < N; i++) begin
        #1;
        step();
        cnt[Z_SEL]++;
      end
      for (int c = 0; c < N; c++) begin
        checks++;
        if (cnt[c] !== 1) begin
          errors++; $display("FAIL fairness[w%0d ch%0d]: got %0d grants expected 1", w, c, cnt[c]);
        end
      end
      $display("fairness window %0d: %0d/%0d/%0d/%0d", w, cnt[0], cnt[1], cnt[2], cnt[3]);
    end
  endtask

  task automatic test_async_reset();
    Z_READY = 1'b1; A_VALID = 4'b1110; A_LAST = 4'b0000;
    #1;
    step();
    Z_READY = 1'b0;
    #1;
    checks++;
    if (Z_VALID !== 1'b1) begin errors++; $display("FAIL areset_setup: got v=%b expected 1", Z_VALID); end
    RST = 1'b1;
    m_reset();
    #1;
    checks++;
    if (Z_VALID !== 1'b0 || Z_DATA !== 8'h00 || Z_SEL !== 2'd0 || A_READY !== 4'b0000) begin
      errors++; $display("FAIL areset_immediate: got v=%b data=%h sel=%0d rdy=%b expected 0/00/0/0000",
                         Z_VALID, Z_DATA, Z_SEL, A_READY);
    end
    @(posedge CK); #2;
    RST = 1'b0;
    A_VALID = 4'b1111; A_LAST = 4'b1111; Z_READY = 1'b1;
    #1;
    checks++;
    if (A_READY !== 4'b0001) begin
      errors++; $display("FAIL areset_first_ready: got %b expected 0001", A_READY);
    end
    step();
    checks++;
    if (Z_VALID !== 1'b1 || Z_SEL !== 2'd0) begin
      errors++; $display("FAIL areset_first_grant: got v=%b sel=%0d expected v=1 sel=0", Z_VALID, Z_SEL);
    end
    $display("async_reset: first grant after release Z_SEL=%0d", Z_SEL);
  endtask

`ifdef HDMUX_LOCK_EN
  task automatic test_lock();
    int exp_sel [4] = '{1, 1, 1, 2};
    A_DATA = {8'h43, 8'h32, 8'h21, 8'h10};
    Z_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        // Channel 1 idles mid-packet: channel 2 must not be granted.
        A_VALID = 4'b0100; A_LAST = 4'b0000;
        #1;
        checks++;
        if (A_READY !== 4'b0000) begin
          errors++; $display("FAIL lock_gap_ready: got %b expected 0000", A_READY);
        end
        step();
        checks++;
        if (Z_VALID !== 1'b0) begin
          errors++; $display("FAIL lock_gap_out: got v=%b sel=%0d expected v=0", Z_VALID, Z_SEL);
        end
      end
      A_VALID = 4'b0110;
      A_LAST  = (i == 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++;
      if (A_READY !== m_ready()) begin
        errors++; $display("FAIL lock_ready[%0d]: got %b expected %b", i, A_READY, m_ready());
      end
      step();
      checks++;
      if (Z_VALID !== 1'b1 || Z_SEL !== SELW'(exp_sel[i]) || Z_SEL !== m_zs) begin
        errors++; $display("FAIL lock_beat[%0d]: got v=%b sel=%0d expected v=1 sel=%0d",
                           i, Z_VALID, Z_SEL, exp_sel[i]);
      end
      $display("lock beat %0d: Z_SEL=%0d", i, Z_SEL);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_back_pressure();
    test_random();
    test_fairness();
    test_async_reset();
`ifdef HDMUX_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
